cpu_dp_mc: RTL and testbench

Parametrised, multi-cycle successor to the CPU datapath. Holds a 2^RA × BW register file, a single-cycle ALU/shifter and an iterative shift-add multiplier. Operand and write-back muxing are driven by a decoded control word, and a valid/ready handshake lets the control unit stall while a multiply runs. It sits between the control unit (instruction fields, PC) and memory (address, data out, data in).

---
 rtl/cpu_dp_pkg.sv | 29 ++
 rtl/cpu_dp_mul.sv | 64 ++++++
 rtl/cpu_dp_mc.sv | 177 +++++++++++++++++
 tb/tb_cpu_dp_mc.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_dp_pkg.sv
// Shared definitions for the multi-cycle datapath: function-select codes,
// the IDLE/MUL sequencer states and the bit positions inside the psw.
package cpu_dp_pkg;

    localparam logic [4:0] FS_MOVA = 5'h00;
    localparam logic [4:0] FS_INC  = 5'h01;
    localparam logic [4:0] FS_ADD  = 5'h02;
    localparam logic [4:0] FS_SUB  = 5'h05;
    localparam logic [4:0] FS_DEC  = 5'h06;
    localparam logic [4:0] FS_AND  = 5'h08;
    localparam logic [4:0] FS_OR   = 5'h0A;
    localparam logic [4:0] FS_XOR  = 5'h0C;
    localparam logic [4:0] FS_NOT  = 5'h0E;
    localparam logic [4:0] FS_MOVB = 5'h10;
    localparam logic [4:0] FS_SHR  = 5'h14;
    localparam logic [4:0] FS_SHL  = 5'h18;
    localparam logic [4:0] FS_MUL  = 5'h1C;

    localparam int PSW_Z = 0;
    localparam int PSW_N = 1;
    localparam int PSW_C = 2;
    localparam int PSW_V = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_dp_mul.sv
// Iterative shift-add multiplier, one iteration per cycle for BW cycles.
// done is high during the final iteration; product shows that iteration's result.
module cpu_dp_mul #(
    parameter int BW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BW-1:0]   a,
    input  logic [BW-1:0]   b,
    output logic            busy,
    output logic            done,
    output logic [2*BW-1:0] product
);
    localparam int CW = $clog2(BW + 1);

    logic [BW-1:0]   a_q, a_d;
    logic [2*BW-1:0] acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic [BW:0]     upper;

    // acc holds {partial sum, remaining multiplier bits}; it shifts right each step
    always_comb begin
        a_d     = a_q;
        acc_d   = acc_q;
        count_d = count_q;
        busy_d  = busy_q;
        upper   = '0;
        if (busy_q) begin
            upper   = {1'b0, acc_q[2*BW-1:BW]} + (acc_q[0] ? {1'b0, a_q} : '0);
            acc_d   = {upper, acc_q[BW-1:1]};
            count_d = count_q + CW'(1);
            if (count_q == CW'(BW - 1)) begin
                busy_d  = 1'b0;
                count_d = '0;
            end
        end else if (start) begin
            a_d     = a;
            acc_d   = {{BW{1'b0}}, b};
            count_d = '0;
            busy_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q     <= '0;
            acc_q   <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (count_q == CW'(BW - 1));
    assign product = acc_d;

endmodule

// File: rtl/cpu_dp_mc.sv
// Multi-cycle CPU datapath: register file, single-cycle ALU/shifter and an
// iterative multiplier behind a valid/ready handshake to the control unit.
module cpu_dp_mc
    import cpu_dp_pkg::*;
#(
    parameter int BW = 16,
    parameter int RA = 3,
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [RA-1:0] da,
    input  logic [RA-1:0] aa,
    input  logic [RA-1:0] ba,
    input  logic [IW-1:0] imm,
    input  logic [4:0]    fs,
    input  logic          mb,
    input  logic          md,
    input  logic          rw,
    input  logic          mm,
    input  logic [BW-1:0] din,
    input  logic [BW-1:0] pc,
    output logic [BW-1:0] addr,
    output logic [BW-1:0] dout,
    output logic [3:0]    psw,
    output logic          mul_done,
    input  logic [RA-1:0] dbg_sel,
    output logic [BW-1:0] dbg_data
);
    localparam int NREG = 2 ** RA;

    logic [BW-1:0]   regs_q [NREG];
    logic [BW-1:0]   regs_d [NREG];
    state_e          state_q, state_d;
    logic [3:0]      psw_q, psw_d;
    logic            mul_done_q, mul_done_d;
    logic [RA-1:0]   mul_da_q, mul_da_d;
    logic            mul_rw_q, mul_rw_d;

    logic [BW-1:0]   bus_a, bus_b, alu_res;
    logic [BW:0]     sum;
    logic            alu_c, alu_v, mul_start, mul_busy, mul_fin;
    logic [2*BW-1:0] mul_prod;

    assign bus_a    = regs_q[aa];
    assign bus_b    = mb ? BW'(imm) : regs_q[ba];
    assign addr     = mm ? pc : bus_a;
    assign dout     = bus_b;
    assign dbg_data = regs_q[dbg_sel];
    assign in_ready = (state_q == IDLE);
    assign psw      = psw_q;
    assign mul_done = mul_done_q;

    always_comb begin
        sum     = '0;
        alu_res = bus_a;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (fs)
            FS_INC: begin
                sum     = {1'b0, bus_a} + {{BW{1'b0}}, 1'b1};
                alu_res = sum[BW-1:0];
                alu_c   = sum[BW];
                alu_v   = ~bus_a[BW-1] & alu_res[BW-1];
            end
            FS_ADD: begin
                sum     = {1'b0, bus_a} + {1'b0, bus_b};
                alu_res = sum[BW-1:0];
                alu_c   = sum[BW];
                alu_v   = (bus_a[BW-1] == bus_b[BW-1]) & (alu_res[BW-1] != bus_a[BW-1]);
            end
            FS_SUB: begin
                sum     = {1'b0, bus_a} + {1'b0, ~bus_b} + {{BW{1'b0}}, 1'b1};
                alu_res = sum[BW-1:0];
                alu_c   = sum[BW];
                alu_v   = (bus_a[BW-1] != bus_b[BW-1]) & (alu_res[BW-1] != bus_a[BW-1]);
            end
            FS_DEC: begin
                // A + all-ones: carry is set unless A was zero (borrow)
                sum     = {1'b0, bus_a} + {1'b0, {BW{1'b1}}};
                alu_res = sum[BW-1:0];
                alu_c   = sum[BW];
                alu_v   = bus_a[BW-1] & ~alu_res[BW-1];
            end
            FS_AND:  alu_res = bus_a & bus_b;
            FS_OR:   alu_res = bus_a | bus_b;
            FS_XOR:  alu_res = bus_a ^ bus_b;
            FS_NOT:  alu_res = ~bus_a;
            FS_MOVB: alu_res = bus_b;
            FS_SHR: begin
                alu_res = {1'b0, bus_b[BW-1:1]};
                alu_c   = bus_b[0];
            end
            FS_SHL: begin
                alu_res = {bus_b[BW-2:0], 1'b0};
                alu_c   = bus_b[BW-1];
            end
            default: alu_res = bus_a;
        endcase
    end

    cpu_dp_mul #(.BW(BW)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (bus_a),
        .b       (bus_b),
        .busy    (mul_busy),
        .done    (mul_fin),
        .product (mul_prod)
    );

    always_comb begin
        regs_d     = regs_q;
        state_d    = state_q;
        psw_d      = psw_q;
        mul_done_d = 1'b0;
        mul_da_d   = mul_da_q;
        mul_rw_d   = mul_rw_q;
        mul_start  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (fs == FS_MUL) begin
                        mul_start = 1'b1;
                        mul_da_d  = da;
                        mul_rw_d  = rw;
                        state_d   = MUL;
                    end else if (rw) begin
                        regs_d[da] = md ? din : alu_res;
                        if (!md) begin
                            psw_d[PSW_V] = alu_v;
                            psw_d[PSW_C] = alu_c;
                            psw_d[PSW_N] = alu_res[BW-1];
                            psw_d[PSW_Z] = (alu_res == '0);
                        end
                    end
                end
            end
            MUL: begin
                if (mul_busy && mul_fin) begin
                    state_d    = IDLE;
                    mul_done_d = 1'b1;
                    if (mul_rw_q) begin
                        regs_d[mul_da_q] = mul_prod[BW-1:0];
                        psw_d[PSW_V] = 1'b0;
                        psw_d[PSW_C] = (mul_prod[2*BW-1:BW] != '0);
                        psw_d[PSW_N] = mul_prod[BW-1];
                        psw_d[PSW_Z] = (mul_prod[BW-1:0] == '0);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
            state_q    <= IDLE;
            psw_q      <= '0;
            mul_done_q <= 1'b0;
            mul_da_q   <= '0;
            mul_rw_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            state_q    <= state_d;
            psw_q      <= psw_d;
            mul_done_q <= mul_done_d;
            mul_da_q   <= mul_da_d;
            mul_rw_q   <= mul_rw_d;
        end
    end

endmodule

// File: tb/tb_cpu_dp_mc.sv
// Directed bench for cpu_dp_mc: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_cpu_dp_mc;
    import cpu_dp_pkg::*;

    localparam int BW = 16;
    localparam int RA = 3;
    localparam int IW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [RA-1:0] da, aa, ba, dbg_sel;
    logic [IW-1:0] imm;
    logic [4:0]    fs;
    logic          mb, md, rw, mm;
    logic [BW-1:0] din, pc, addr, dout, dbg_data;
    logic [3:0]    psw;
    logic          mul_done;

    logic [BW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int low_cnt;
    int pulses;

    cpu_dp_mc #(.BW(BW), .RA(RA), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .da       (da),
        .aa       (aa),
        .ba       (ba),
        .imm      (imm),
        .fs       (fs),
        .mb       (mb),
        .md       (md),
        .rw       (rw),
        .mm       (mm),
        .din      (din),
        .pc       (pc),
        .addr     (addr),
        .dout     (dout),
        .psw      (psw),
        .mul_done (mul_done),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard
    task automatic check(input string tag, input logic [BW-1:0] obs);
        logic [BW-1:0] exp;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: observed %h but scoreboard empty", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input logic [BW-1:0] exp, input logic [BW-1:0] obs);
        exp_q.push_back(exp);
        check(tag, obs);
    endtask

    task automatic expect_reg(input string tag, input logic [RA-1:0] r, input logic [BW-1:0] exp);
        exp_q.push_back(exp);
        dbg_sel = r;
        #1;
        check(tag, dbg_data);
    endtask

    // driver: aligns to a negedge, presents one control word for one edge
    task automatic issue(input logic [4:0] f, input logic [RA-1:0] d, a, b,
                         input logic [IW-1:0] im, input logic m_b, m_d, r_w,
                         input logic [BW-1:0] dat);
        @(negedge clk);
        fs = f; da = d; aa = a; ba = b; imm = im;
        mb = m_b; md = m_d; rw = r_w; din = dat;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [RA-1:0] d, input logic [BW-1:0] v);
        issue(FS_MOVA, d, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, v);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; da = '0; aa = '0; ba = '0; imm = '0;
        fs = FS_MOVA; mb = 1'b0; md = 1'b0; rw = 1'b0; mm = 1'b0;
        din = '0; pc = '0; dbg_sel = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) expect_reg($sformatf("rst_r%0d", i), 3'(i), 16'h0000);
        expect_sig("rst_psw", 16'h0000, {12'h0, psw});
        expect_sig("rst_ready", 16'h0001, {15'h0, in_ready});

        issue(FS_MOVB, 3'd1, 3'd0, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0);
        expect_reg("movb_r1", 3'd1, 16'h0005);
        issue(FS_ADD, 3'd2, 3'd1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("add_r2", 3'd2, 16'h000A);
        expect_sig("add_psw", 16'h0000, {12'h0, psw});
        issue(FS_SUB, 3'd4, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("sub_r4", 3'd4, 16'h0005);
        expect_sig("sub_psw", 16'h0004, {12'h0, psw});
        issue(FS_DEC, 3'd6, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("dec_r6", 3'd6, 16'hFFFF);
        expect_sig("dec_psw", 16'h0002, {12'h0, psw});
        issue(FS_XOR, 3'd4, 3'd6, 3'd0, 3'd3, 1'b1, 1'b0, 1'b1, 16'h0);
        expect_reg("xor_r4", 3'd4, 16'hFFFC);
        expect_sig("xor_psw", 16'h0002, {12'h0, psw});

        load(3'd3, 16'h7FFF);
        expect_sig("load_psw_kept", 16'h0002, {12'h0, psw});
        issue(FS_INC, 3'd4, 3'd3, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("inc_ovf_r4", 3'd4, 16'h8000);
        expect_sig("inc_ovf_psw", 16'h000A, {12'h0, psw});
        load(3'd5, 16'hFFFF);
        issue(FS_INC, 3'd6, 3'd5, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("inc_wrap_r6", 3'd6, 16'h0000);
        expect_sig("inc_wrap_psw", 16'h0005, {12'h0, psw});

        // multiply 0x0300 * 0x0100 with a stray fire attempted mid-run
        load(3'd1, 16'h0300);
        load(3'd2, 16'h0100);
        issue(FS_MUL, 3'd7, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        low_cnt = 0;
        pulses = 0;
        while (!in_ready && low_cnt < 40) begin
            if (mul_done) pulses++;
            if (low_cnt == 4) begin
                fs = FS_MOVB; da = 3'd6; imm = 3'd7; mb = 1'b1; rw = 1'b1; md = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            low_cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        expect_sig("mul_busy_cycles", 16'd16, 16'(low_cnt));
        expect_sig("mul_early_done", 16'd0, 16'(pulses));
        expect_sig("mul_done_hi", 16'h0001, {15'h0, mul_done});
        expect_reg("mul_r7", 3'd7, 16'h0000);
        expect_sig("mul_psw", 16'h0005, {12'h0, psw});
        expect_reg("mul_stray_r6", 3'd6, 16'h0000);
        @(negedge clk);
        expect_sig("mul_done_lo", 16'h0000, {15'h0, mul_done});

        // multiply with immediate operand, nonzero low half
        load(3'd3, 16'h1234);
        issue(FS_MUL, 3'd7, 3'd3, 3'd0, 3'd5, 1'b1, 1'b0, 1'b1, 16'h0);
        low_cnt = 0;
        while (!in_ready && low_cnt < 40) begin
            low_cnt++;
            @(negedge clk);
        end
        expect_sig("mul2_busy_cycles", 16'd16, 16'(low_cnt));
        expect_reg("mul2_r7", 3'd7, 16'h5B04);
        expect_sig("mul2_psw", 16'h0000, {12'h0, psw});

        // reset at cycle 8 of a multiply
        issue(FS_MUL, 3'd7, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        expect_sig("rstmul_ready", 16'h0001, {15'h0, in_ready});
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (mul_done) pulses++;
            @(negedge clk);
        end
        expect_sig("rstmul_no_done", 16'd0, 16'(pulses));
        expect_reg("rstmul_r7", 3'd7, 16'h0000);

        // load keeps psw; address and write-data muxes
        issue(FS_DEC, 3'd1, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        load(3'd3, 16'hBEEF);
        expect_reg("ld_r3", 3'd3, 16'hBEEF);
        expect_sig("ld_psw", 16'h0002, {12'h0, psw});
        @(negedge clk);
        mm = 1'b1; pc = 16'h1234; aa = 3'd3; mb = 1'b1; imm = 3'd6; ba = 3'd3;
        #1;
        expect_sig("addr_pc", 16'h1234, addr);
        expect_sig("dout_imm", 16'h0006, dout);
        mm = 1'b0; mb = 1'b0;
        #1;
        expect_sig("addr_busa", 16'hBEEF, addr);
        expect_sig("dout_reg", 16'hBEEF, dout);

        // shifts
        load(3'd2, 16'h0001);
        issue(FS_SHR, 3'd4, 3'd2, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("shr_r4", 3'd4, 16'h0000);
        expect_sig("shr_psw", 16'h0005, {12'h0, psw});
        issue(FS_SHL, 3'd5, 3'd3, 3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0);
        expect_reg("shl_r5", 3'd5, 16'h7DDE);
        expect_sig("shl_psw", 16'h0004, {12'h0, psw});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
